// File: rtl/al_pkg.sv
// Shared definitions for the AL copy initiator: FSM encoding, credit sizing
// and wrap-around word-address arithmetic.
package al_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Credits count 0..2^abits inclusive, so they need one extra bit.
    function automatic int unsigned credit_width(input int unsigned abits);
        return abits + 1;
    endfunction

    function automatic logic [31:0] word_addr_add(input logic [31:0] base,
                                                  input logic [31:0] off,
                                                  input int unsigned width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (base + off) & mask;
    endfunction

endpackage

// File: rtl/al_rdata_fifo.sv
// Show-ahead read-data FIFO: head is valid whenever count != 0; push and pop
// may happen in the same cycle.
module al_rdata_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ABITS      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [ABITS:0]        count
);
    localparam int CW = ABITS + 1;

    logic [DATA_WIDTH-1:0] mem [2**ABITS];
    logic [ABITS-1:0]      wptr;
    logic [ABITS-1:0]      rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/al_copy_initiator.sv
// AL bus copy initiator: streams cfg_len words from cfg_src to cfg_dst, with
// reads running ahead of writes through a credit-bounded data FIFO.
module al_copy_initiator
    import al_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_BITS  = 2,
    parameter int DATA_WIDTH = 8 << DATA_BITS,
    parameter int ID_WIDTH   = 1,
    parameter int LEN_WIDTH  = ADDR_WIDTH - DATA_BITS + 1,
    parameter int FIFO_ABITS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:DATA_BITS] cfg_src,
    input  logic [ADDR_WIDTH-1:DATA_BITS] cfg_dst,
    input  logic [LEN_WIDTH-1:0]          cfg_len,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [ADDR_WIDTH-1:DATA_BITS] m_al_waddr,
    output logic                          m_al_wvalid,
    output logic [DATA_WIDTH-1:0]         m_al_wdata,
    input  logic                          m_al_wready,
    output logic [ADDR_WIDTH-1:DATA_BITS] m_al_araddr,
    output logic                          m_al_arvalid,
    output logic [ID_WIDTH-1:0]           m_al_arid,
    input  logic                          m_al_arready,
    input  logic [DATA_WIDTH-1:0]         m_al_rdata,
    input  logic                          m_al_rvalid,
    input  logic [ID_WIDTH-1:0]           m_al_rid,
    output logic                          m_al_rready
);
    localparam int AW = ADDR_WIDTH - DATA_BITS;
    localparam int CW = credit_width(FIFO_ABITS);
    localparam logic [CW-1:0] DEPTH = CW'(1 << FIFO_ABITS);

    state_t                state;
    logic                  up;
    logic [AW-1:0]         src;
    logic [AW-1:0]         dst;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  rd_cnt;
    logic [LEN_WIDTH-1:0]  rsp_cnt;
    logic [LEN_WIDTH-1:0]  wr_cnt;
    logic [CW-1:0]         in_flight;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         credit;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  start;
    logic                  ar_fire;
    logic                  w_fire;
    logic                  rsp;
    logic                  last_w;
    logic                  id_bad;

    // Handshake: valid is raised independently of ready; while valid is high
    // and ready is low, address/data/ID are held, and valid only falls after
    // acceptance (or on rst). Credit only shrinks on ar acceptance, and the
    // counters feeding the addresses only move on acceptance, so this holds
    // by construction.
    assign credit  = DEPTH - fifo_count - in_flight;
    assign start   = cfg_valid && cfg_ready;
    assign ar_fire = m_al_arvalid && m_al_arready;
    assign w_fire  = m_al_wvalid && m_al_wready;
    assign rsp     = m_al_rvalid && m_al_rready;
    assign last_w  = w_fire && ((wr_cnt + LEN_WIDTH'(1)) == len);
    assign id_bad  = rsp && (m_al_rid != rsp_cnt[ID_WIDTH-1:0]);

    assign m_al_arvalid = (state == S_RUN) && (rd_cnt < len) && (credit != '0);
    assign m_al_araddr  = AW'(word_addr_add(32'(src), 32'(rd_cnt), AW));
    assign m_al_arid    = rd_cnt[ID_WIDTH-1:0];
    assign m_al_wvalid  = (fifo_count != '0);
    assign m_al_waddr   = AW'(word_addr_add(32'(dst), 32'(wr_cnt), AW));
    assign m_al_wdata   = fifo_head;
    assign m_al_rready  = up;

    assign cfg_ready = up && (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            up    <= 1'b0;
        end else begin
            up <= 1'b1;
            case (state)
                S_IDLE:  if (start) state <= (cfg_len == '0) ? S_DONE : S_RUN;
                S_RUN:   if (last_w) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src       <= '0;
            dst       <= '0;
            len       <= '0;
            rd_cnt    <= '0;
            rsp_cnt   <= '0;
            wr_cnt    <= '0;
            in_flight <= '0;
            err       <= 1'b0;
        end else begin
            if (start) begin
                src     <= cfg_src;
                dst     <= cfg_dst;
                len     <= cfg_len;
                rd_cnt  <= '0;
                rsp_cnt <= '0;
                wr_cnt  <= '0;
                err     <= 1'b0;
            end else begin
                if (ar_fire) rd_cnt  <= rd_cnt + LEN_WIDTH'(1);
                if (rsp)     rsp_cnt <= rsp_cnt + LEN_WIDTH'(1);
                if (w_fire)  wr_cnt  <= wr_cnt + LEN_WIDTH'(1);
                if (id_bad)  err     <= 1'b1;
            end
            in_flight <= in_flight + CW'(ar_fire) - CW'(rsp);
        end
    end

    al_rdata_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .ABITS     (FIFO_ABITS)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (rsp),
        .wdata(m_al_rdata),
        .pop  (w_fire),
        .head (fifo_head),
        .count(fifo_count)
    );

endmodule

// File: tb/tb_al_copy_initiator.sv
// Directed bench for al_copy_initiator with a behavioural AL slave memory.
module tb_al_copy_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  cfg_src = '0;
    logic [9:0]  cfg_dst = '0;
    logic [10:0] cfg_len = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready, busy, done, err;
    logic [9:0]  m_al_waddr, m_al_araddr;
    logic        m_al_wvalid, m_al_arvalid, m_al_rready;
    logic [31:0] m_al_wdata;
    logic        m_al_wready = 1'b1;
    logic        m_al_arready = 1'b1;
    logic [0:0]  m_al_arid;
    logic [31:0] m_al_rdata = '0;
    logic        m_al_rvalid = 1'b0;
    logic [0:0]  m_al_rid = '0;

    always #5 clk = ~clk;

    al_copy_initiator dut (
        .clk(clk), .rst(rst),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .busy(busy), .done(done), .err(err),
        .m_al_waddr(m_al_waddr), .m_al_wvalid(m_al_wvalid),
        .m_al_wdata(m_al_wdata), .m_al_wready(m_al_wready),
        .m_al_araddr(m_al_araddr), .m_al_arvalid(m_al_arvalid),
        .m_al_arid(m_al_arid), .m_al_arready(m_al_arready),
        .m_al_rdata(m_al_rdata), .m_al_rvalid(m_al_rvalid),
        .m_al_rid(m_al_rid), .m_al_rready(m_al_rready)
    );

    // Slave: 1-cycle read latency, optional random ready, optional rid flip.
    logic [31:0] mem [0:1023];
    logic        bp = 1'b0;
    logic        w_hold = 1'b0;
    int          flip_idx = -1;
    int          ar_total = 0, w_total = 0, arv_cycles = 0, wv_cycles = 0;
    logic [9:0]  ar_addr_q[$];
    logic [9:0]  w_addr_q[$];

    always @(posedge clk) begin
        m_al_arready <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
        m_al_wready  <= w_hold ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
        if (rst) begin
            m_al_rvalid <= 1'b0;
        end else begin
            m_al_rvalid <= m_al_arvalid && m_al_arready;
            m_al_rdata  <= mem[m_al_araddr];
            m_al_rid    <= m_al_arid ^ 1'(ar_total == flip_idx);
            if (m_al_arvalid && m_al_arready) begin
                ar_total <= ar_total + 1;
                ar_addr_q.push_back(m_al_araddr);
            end
            if (m_al_wvalid && m_al_wready) begin
                mem[m_al_waddr] <= m_al_wdata;
                w_total <= w_total + 1;
                w_addr_q.push_back(m_al_waddr);
            end
            if (m_al_arvalid) arv_cycles <= arv_cycles + 1;
            if (m_al_wvalid)  wv_cycles  <= wv_cycles + 1;
        end
    end

    // Valid-before-ready stability monitor.
    logic        p_rst = 1'b1, p_arv = 1'b0, p_arr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
    logic [9:0]  p_araddr = '0, p_waddr = '0;
    logic [0:0]  p_arid = '0;
    logic [31:0] p_wdata = '0;
    int          hs_viol = 0;

    always @(posedge clk) begin
        if (!p_rst && p_arv && !p_arr &&
            !(m_al_arvalid && m_al_araddr == p_araddr && m_al_arid == p_arid))
            hs_viol++;
        if (!p_rst && p_wv && !p_wr &&
            !(m_al_wvalid && m_al_waddr == p_waddr && m_al_wdata == p_wdata))
            hs_viol++;
        p_rst = rst; p_arv = m_al_arvalid; p_arr = m_al_arready;
        p_wv = m_al_wvalid; p_wr = m_al_wready;
        p_araddr = m_al_araddr; p_arid = m_al_arid;
        p_waddr = m_al_waddr; p_wdata = m_al_wdata;
    end

    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input logic [9:0] s, input int l);
        logic [9:0] a;
        exp_q.delete();
        for (int k = 0; k < l; k++) begin
            a = s + 10'(k);
            exp_q.push_back(mem[a]);
        end
    endtask

    task automatic check_mem(input string tag, input logic [9:0] d, input int l);
        logic [9:0]  a;
        logic [31:0] e;
        for (int k = 0; k < l; k++) begin
            a = d + 10'(k);
            e = exp_q.pop_front();
            chk(tag, mem[a], e);
        end
    endtask

    task automatic start_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] l);
        chk("cfg_ready_before_start", cfg_ready, 1);
        cfg_src = s; cfg_dst = d; cfg_len = l; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // n counts cycles from the start cycle; returns in the done cycle.
    task automatic wait_done(input string tag, input int budget, output int n);
        n = 1;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base_ar, base_w, base_arv, base_wv;
        logic [9:0] ea [4];
        logic [9:0] ew [4];
        logic [9:0] rs, rd;
        int rl;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + 32'(i);

        // Reset state
        repeat (3) tick();
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_arvalid", m_al_arvalid, 0);
        chk("rst_wvalid", m_al_wvalid, 0);
        chk("rst_rready", m_al_rready, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_cfg_ready", cfg_ready, 1);
        chk("post_rst_rready", m_al_rready, 1);

        // Latency, len=1
        snap(10'h005, 1);
        start_copy(10'h005, 10'h220, 11'd1);
        chk("lat_arvalid", m_al_arvalid, 1);
        chk("lat_araddr", m_al_araddr, 10'h005);
        chk("lat_busy", busy, 1);
        tick();
        chk("lat_rvalid", m_al_rvalid, 1);
        tick();
        chk("lat_wvalid", m_al_wvalid, 1);
        chk("lat_waddr", m_al_waddr, 10'h220);
        chk("lat_wdata", m_al_wdata, 32'hC0DE_0005);
        tick();
        chk("lat_done", done, 1);
        tick();
        chk("lat_done_pulse", done, 0);
        check_mem("lat_mem", 10'h220, 1);

        // T1: 8 words, full rate
        base_ar = ar_total; base_w = w_total;
        snap(10'h010, 8);
        start_copy(10'h010, 10'h200, 11'd8);
        wait_done("t1_done_seen", 100, n);
        chk("t1_done_cycle", n, 11);
        chk("t1_reads", ar_total - base_ar, 8);
        chk("t1_writes", w_total - base_w, 8);
        tick();
        check_mem("t1_mem", 10'h200, 8);

        // T2: len=0
        base_arv = arv_cycles; base_wv = wv_cycles;
        start_copy(10'h000, 10'h000, 11'd0);
        chk("t2_done", done, 1);
        chk("t2_cfg_ready_low", cfg_ready, 0);
        tick();
        chk("t2_done_low", done, 0);
        chk("t2_cfg_ready", cfg_ready, 1);
        chk("t2_no_arvalid", arv_cycles - base_arv, 0);
        chk("t2_no_wvalid", wv_cycles - base_wv, 0);

        // T3: write stall bounded by FIFO credit
        w_hold = 1'b1;
        base_ar = ar_total; base_w = w_total;
        snap(10'h040, 10);
        start_copy(10'h040, 10'h300, 11'd10);
        repeat (20) tick();
        chk("t3_reads_stalled", ar_total - base_ar, 4);
        chk("t3_arvalid_low", m_al_arvalid, 0);
        chk("t3_no_writes", w_total - base_w, 0);
        w_hold = 1'b0;
        wait_done("t3_done_seen", 200, n);
        chk("t3_reads_total", ar_total - base_ar, 10);
        tick();
        check_mem("t3_mem", 10'h300, 10);

        // T4: address wrap on both channels
        ar_addr_q.delete(); w_addr_q.delete();
        ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        ew = '{10'h3FD, 10'h3FE, 10'h3FF, 10'h000};
        snap(10'h3FE, 4);
        start_copy(10'h3FE, 10'h3FD, 11'd4);
        wait_done("t4_done_seen", 100, n);
        tick();
        chk("t4_ar_count", ar_addr_q.size(), 4);
        chk("t4_w_count", w_addr_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("t4_araddr", ar_addr_q[k], ea[k]);
            chk("t4_waddr", w_addr_q[k], ew[k]);
        end
        check_mem("t4_mem", 10'h3FD, 4);

        // T5: rid mismatch -> sticky err, data still copied
        flip_idx = ar_total;
        snap(10'h020, 3);
        start_copy(10'h020, 10'h180, 11'd3);
        wait_done("t5_done_seen", 100, n);
        chk("t5_err_at_done", err, 1);
        flip_idx = -1;
        tick();
        chk("t5_err_sticky", err, 1);
        check_mem("t5_mem", 10'h180, 3);
        snap(10'h030, 1);
        start_copy(10'h030, 10'h190, 11'd1);
        chk("t5_err_cleared", err, 0);
        wait_done("t5b_done_seen", 100, n);
        chk("t5_err_stays_clear", err, 0);
        tick();
        check_mem("t5b_mem", 10'h190, 1);

        // T6: reset mid-copy, then a fresh copy
        base_w = w_total;
        start_copy(10'h050, 10'h280, 11'd8);
        n = 0;
        while ((w_total - base_w) < 3 && n < 100) begin
            tick();
            n++;
        end
        chk("t6_three_writes", w_total - base_w, 3);
        rst = 1'b1;
        tick();
        chk("t6_arvalid", m_al_arvalid, 0);
        chk("t6_wvalid", m_al_wvalid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        rst = 1'b0;
        tick();
        chk("t6_cfg_ready", cfg_ready, 1);
        snap(10'h060, 2);
        start_copy(10'h060, 10'h2C0, 11'd2);
        wait_done("t6_done_seen", 50, n);
        chk("t6_done_cycle", n, 5);
        tick();
        check_mem("t6_mem", 10'h2C0, 2);

        // Backpressure on ar and w
        bp = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rs = 10'($urandom_range(0, 239));
            rd = 10'(256 + $urandom_range(0, 239));
            rl = $urandom_range(1, 16);
            snap(rs, rl);
            start_copy(rs, rd, 11'(rl));
            wait_done("bp_done_seen", 600, n);
            tick();
            check_mem("bp_mem", rd, rl);
        end
        bp = 1'b0;
        tick();

        chk("handshake_stable", hs_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
